// File: rtl/gyro_sequencer.sv
// gyro_sequencer: drives the gyro SPI wrapper through one-time init and periodic reads,
// registers each X/Y/Z triple behind a valid/ready handshake and supervises every
// wrapper transaction with a timeout, plus overrun and drop accounting.
module gyro_sequencer #(
    parameter int unsigned SAMPLE_PERIOD = 100000,
    parameter int unsigned TIMEOUT       = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    output logic               gyro_start,
    input  logic               gyro_done_init,
    input  logic               gyro_done_read,
    input  logic signed [15:0] gyro_x,
    input  logic signed [15:0] gyro_y,
    input  logic signed [15:0] gyro_z,
    output logic signed [15:0] sample_x,
    output logic signed [15:0] sample_y,
    output logic signed [15:0] sample_z,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic               initialized,
    output logic               timeout_err,
    output logic [7:0]         overrun_count,
    output logic [7:0]         drop_count
);

    typedef enum logic [1:0] {StIdle, StInit, StWait, StRead} state_e;

    state_e             state_q, state_d;
    logic               done_init_q, done_read_q;
    logic               init_ev, read_ev;
    logic [31:0]        period_q;
    logic [31:0]        tmo_q;
    logic               busy, tick, tmo_hit;
    logic               start_d, start_q;
    logic               capture, init_set, tmo_set;
    logic               initialized_q, timeout_err_q, sample_valid_q;
    logic signed [15:0] sample_x_q, sample_y_q, sample_z_q;
    logic [7:0]         overrun_q, drop_q;

    // Rising-edge events, so level-style or pulse-style done outputs both work.
    assign init_ev = gyro_done_init & ~done_init_q;
    assign read_ev = gyro_done_read & ~done_read_q;

    assign busy    = (state_q == StInit) || (state_q == StRead);
    assign tick    = initialized_q && (state_q != StIdle) && (period_q == SAMPLE_PERIOD - 1);
    assign tmo_hit = busy && (tmo_q == TIMEOUT);

    // Register the wrapper done lines for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_init_q <= 1'b0;
            done_read_q <= 1'b0;
        end else begin
            done_init_q <= gyro_done_init;
            done_read_q <= gyro_done_read;
        end
    end

    // Next-state logic; a done event takes priority over a coincident timeout.
    always_comb begin
        state_d  = state_q;
        start_d  = 1'b0;
        capture  = 1'b0;
        init_set = 1'b0;
        tmo_set  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = initialized_q ? StWait : StInit;
                    start_d = ~initialized_q;
                end
            end
            StInit: begin
                if (init_ev) begin
                    init_set = 1'b1;
                    state_d  = enable ? StWait : StIdle;
                end else if (tmo_hit) begin
                    tmo_set = 1'b1;
                    // Retry by re-entering INIT; a dropped enable stops after this attempt.
                    if (enable) start_d = 1'b1;
                    else        state_d = StIdle;
                end
            end
            StWait: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (tick) begin
                    state_d = StRead;
                    start_d = 1'b1;
                end
            end
            StRead: begin
                if (read_ev) begin
                    capture = 1'b1;
                    state_d = enable ? StWait : StIdle;
                end else if (tmo_hit) begin
                    tmo_set = 1'b1;
                    if (enable) start_d = 1'b1;
                    else        state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register and the one-cycle start pulse issued on (re-)entry to INIT/READ.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
        end
    end

    // Transaction timeout counter: cleared with each start pulse, counts while busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_q <= '0;
        end else if (start_d || !busy) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 32'd1;
        end
    end

    // Sample period counter: restarts at init completion, frozen in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_q <= '0;
        end else if (init_set) begin
            period_q <= '0;
        end else if (initialized_q && (state_q != StIdle)) begin
            period_q <= tick ? 32'd0 : period_q + 32'd1;
        end
    end

    // Sticky status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            initialized_q <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            if (init_set) initialized_q <= 1'b1;
            if (tmo_set)  timeout_err_q <= 1'b1;
        end
    end

    // Sample register with valid/ready; a capture during accept keeps valid high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_x_q     <= '0;
            sample_y_q     <= '0;
            sample_z_q     <= '0;
            sample_valid_q <= 1'b0;
        end else if (capture) begin
            sample_x_q     <= gyro_x;
            sample_y_q     <= gyro_y;
            sample_z_q     <= gyro_z;
            sample_valid_q <= 1'b1;
        end else if (sample_valid_q && sample_ready) begin
            sample_valid_q <= 1'b0;
        end
    end

    // Saturating overrun (tick while reading) and drop (overwrite unconsumed) counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun_q <= '0;
            drop_q    <= '0;
        end else begin
            if (tick && (state_q == StRead) && (overrun_q != 8'hFF)) begin
                overrun_q <= overrun_q + 8'd1;
            end
            if (capture && sample_valid_q && !sample_ready && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    assign gyro_start    = start_q;
    assign sample_x      = sample_x_q;
    assign sample_y      = sample_y_q;
    assign sample_z      = sample_z_q;
    assign sample_valid  = sample_valid_q;
    assign initialized   = initialized_q;
    assign timeout_err   = timeout_err_q;
    assign overrun_count = overrun_q;
    assign drop_count    = drop_q;

endmodule

// File: tb/tb_gyro_sequencer.sv
// Directed bench for gyro_sequencer with a small behavioural model of the gyro wrapper.
module tb_gyro_sequencer;

    localparam int unsigned SP  = 10;
    localparam int unsigned TMO = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        gyro_start;
    logic        gyro_done_init;
    logic        gyro_done_read;
    logic [15:0] gyro_x, gyro_y, gyro_z;
    logic [15:0] sample_x, sample_y, sample_z;
    logic        sample_valid;
    logic        sample_ready;
    logic        initialized;
    logic        timeout_err;
    logic [7:0]  overrun_count;
    logic [7:0]  drop_count;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Start-pulse monitor state.
    int   start_cnt    = 0;
    int   last_start   = 0;
    int   start_gap    = 0;
    int   start_double = 0;
    logic start_prev   = 1'b0;

    // Wrapper model controls (written by stimulus) and status (written by the model).
    int init_lat      = 5;
    int read_lat      = 3;
    int suppress_req  = 0;
    int suppress_done = 0;
    int reads_done    = 0;
    int init_cnt      = 0;
    int read_cnt      = 0;

    gyro_sequencer #(
        .SAMPLE_PERIOD (SP),
        .TIMEOUT       (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .gyro_start     (gyro_start),
        .gyro_done_init (gyro_done_init),
        .gyro_done_read (gyro_done_read),
        .gyro_x         (gyro_x),
        .gyro_y         (gyro_y),
        .gyro_z         (gyro_z),
        .sample_x       (sample_x),
        .sample_y       (sample_y),
        .sample_z       (sample_z),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .initialized    (initialized),
        .timeout_err    (timeout_err),
        .overrun_count  (overrun_count),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every start pulse, the spacing between pulses and any pulse longer than a cycle.
    always @(negedge clk) begin
        if (gyro_start === 1'b1) begin
            if (start_prev) start_double <= start_double + 1;
            start_gap  <= cyc - last_start;
            last_start <= cyc;
            start_cnt  <= start_cnt + 1;
        end
        start_prev <= (gyro_start === 1'b1);
    end

    // Wrapper model: answers a start with a one-cycle done pulse after a fixed latency.
    initial begin : wrapper_model
        gyro_done_init = 1'b0;
        gyro_done_read = 1'b0;
        forever begin
            @(negedge clk);
            gyro_done_init = 1'b0;
            gyro_done_read = 1'b0;
            if (rst !== 1'b1) begin
                init_cnt = 0;
                read_cnt = 0;
            end else begin
                if (init_cnt > 0) begin
                    init_cnt = init_cnt - 1;
                    if (init_cnt == 0) gyro_done_init = 1'b1;
                end
                if (read_cnt > 0) begin
                    read_cnt = read_cnt - 1;
                    if (read_cnt == 0) begin
                        gyro_done_read = 1'b1;
                        reads_done     = reads_done + 1;
                    end
                end
                if (gyro_start === 1'b1) begin
                    if (initialized !== 1'b1) begin
                        init_cnt = init_lat;
                    end else if (suppress_done < suppress_req) begin
                        suppress_done = suppress_done + 1;
                        read_cnt      = 0;
                    end else begin
                        read_cnt = read_lat;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Returns in the cycle the model raises done_read for read number 'target'.
    task automatic wait_reads(input int target, input int budget, input string tag);
        int n = 0;
        while (reads_done < target && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(reads_done >= target), 1);
    endtask

    task automatic wait_start(input int budget, input string tag);
        int s = start_cnt;
        int n = 0;
        while (start_cnt == s && n < budget) begin
            step();
            n++;
        end
        check(tag, start_cnt - s, 1);
    endtask

    task automatic wait_init(input int budget, input string tag);
        int n = 0;
        while (initialized !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(initialized), 1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int r;
        int s;
        rst          = 1'b1;
        enable       = 1'b0;
        sample_ready = 1'b0;
        gyro_x       = '0;
        gyro_y       = '0;
        gyro_z       = '0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_start", 32'(gyro_start), 0);
        check("rst_valid", 32'(sample_valid), 0);
        check("rst_init", 32'(initialized), 0);

        // Idle for 1000 cycles with enable low.
        rst = 1'b1;
        repeat (1000) @(negedge clk);
        #1;
        check("idle_starts", start_cnt, 0);
        check("idle_x", 32'(sample_x), 0);
        check("idle_y", 32'(sample_y), 0);
        check("idle_z", 32'(sample_z), 0);
        check("idle_valid", 32'(sample_valid), 0);
        check("idle_init", 32'(initialized), 0);
        check("idle_tmo", 32'(timeout_err), 0);
        check("idle_ovr", 32'(overrun_count), 0);
        check("idle_drop", 32'(drop_count), 0);

        // Bring-up: single init start, then reads every SP cycles, latency 3.
        gyro_x       = 16'h1234;
        gyro_y       = 16'hFFF9;
        gyro_z       = 16'h7FFF;
        sample_ready = 1'b1;
        s            = start_cnt;
        enable       = 1'b1;
        step();
        check("start_after_enable", 32'(gyro_start), 1);
        step();
        check("start_one_cycle", 32'(gyro_start), 0);
        wait_init(100, "init_done");
        check("init_starts", start_cnt - s, 1);
        for (int k = 0; k < 3; k++) begin
            r = reads_done;
            wait_reads(r + 1, 40, "bringup_read");
            step();
            check("bringup_valid", 32'(sample_valid), 1);
            check("bringup_x", 32'(sample_x), 32'h1234);
            check("bringup_y", 32'(sample_y), 32'hFFF9);
            check("bringup_z", 32'(sample_z), 32'h7FFF);
            check("bringup_latency", cyc - last_start, 4);
            if (k > 0) check("bringup_period", start_gap, 10);
        end
        step();
        check("bringup_consumed", 32'(sample_valid), 0);
        check("bringup_drop", 32'(drop_count), 0);
        check("bringup_ovr", 32'(overrun_count), 0);
        check("bringup_tmo", 32'(timeout_err), 0);

        // Backpressure: three reads with ready low -> two drops, last sample kept.
        sample_ready = 1'b0;
        gyro_x = 16'h0001; gyro_y = 16'h0002; gyro_z = 16'h0003;
        r = reads_done;
        wait_reads(r + 1, 40, "bp_read0");
        step();
        gyro_x = 16'h8000; gyro_y = 16'h4000; gyro_z = 16'h2000;
        r = reads_done;
        wait_reads(r + 1, 40, "bp_read1");
        step();
        gyro_x = 16'hABCD; gyro_y = 16'hFFFE; gyro_z = 16'h0F0F;
        r = reads_done;
        wait_reads(r + 1, 40, "bp_read2");
        step();
        check("bp_drop", 32'(drop_count), 2);
        check("bp_x", 32'(sample_x), 32'hABCD);
        check("bp_y", 32'(sample_y), 32'hFFFE);
        check("bp_z", 32'(sample_z), 32'h0F0F);
        check("bp_valid", 32'(sample_valid), 1);
        step();
        check("bp_hold", 32'(sample_valid), 1);
        sample_ready = 1'b1;
        step();
        check("bp_release", 32'(sample_valid), 0);
        check("bp_drop_after", 32'(drop_count), 2);

        // Capture coinciding with accept: new data, valid stays high, no drop.
        sample_ready = 1'b0;
        gyro_x = 16'h1111; gyro_y = 16'h2222; gyro_z = 16'h3333;
        r = reads_done;
        wait_reads(r + 1, 40, "sc_read0");
        step();
        check("sc_valid0", 32'(sample_valid), 1);
        check("sc_drop0", 32'(drop_count), 2);
        gyro_x = 16'h5555; gyro_y = 16'h6666; gyro_z = 16'h7777;
        r = reads_done;
        wait_reads(r + 1, 40, "sc_read1");
        sample_ready = 1'b1;
        step();
        check("sc_valid1", 32'(sample_valid), 1);
        check("sc_x", 32'(sample_x), 32'h5555);
        check("sc_drop1", 32'(drop_count), 2);
        step();
        check("sc_consumed", 32'(sample_valid), 0);

        // Timeout: one read goes unanswered -> restart 51 cycles later, 5 overruns.
        gyro_x       = 16'h0C0C;
        suppress_req = 1;
        r = reads_done;
        wait_reads(r + 1, 120, "tmo_read");
        step();
        check("tmo_gap", start_gap, 51);
        check("tmo_err", 32'(timeout_err), 1);
        check("tmo_ovr", 32'(overrun_count), 5);
        check("tmo_x", 32'(sample_x), 32'h0C0C);
        check("tmo_latency", cyc - last_start, 4);
        r = reads_done;
        wait_reads(r + 1, 40, "tmo_next_read");
        step();
        check("tmo_sticky", 32'(timeout_err), 1);
        check("tmo_ovr_hold", 32'(overrun_count), 5);
        check("tmo_next_valid", 32'(sample_valid), 1);

        // Overrun: latency 25 with period 10 -> two overruns per read, saturating.
        read_lat = 25;
        r = reads_done;
        wait_reads(r + 1, 60, "ovr_first");
        step();
        check("ovr_plus2", 32'(overrun_count), 7);
        for (int i = 0; i < 130; i++) begin
            r = reads_done;
            wait_reads(r + 1, 60, "ovr_read");
        end
        step();
        check("ovr_sat", 32'(overrun_count), 255);
        check("ovr_gap", start_gap, 30);
        check("ovr_drop", 32'(drop_count), 2);

        // Disable mid-read: the read completes, then the block idles.
        gyro_x = 16'h0BAD; gyro_y = 16'h8001; gyro_z = 16'hFFFF;
        wait_start(40, "dis_start");
        enable = 1'b0;
        r = reads_done;
        wait_reads(r + 1, 40, "dis_read");
        step();
        check("dis_x", 32'(sample_x), 32'h0BAD);
        check("dis_y", 32'(sample_y), 32'h8001);
        check("dis_z", 32'(sample_z), 32'hFFFF);
        check("dis_valid", 32'(sample_valid), 1);
        s = start_cnt;
        repeat (40) step();
        check("dis_idle", start_cnt - s, 0);
        check("dis_init_kept", 32'(initialized), 1);
        check("dis_ovr_kept", 32'(overrun_count), 255);

        // Re-enable goes straight to reads; reset in the middle of one.
        enable = 1'b1;
        wait_start(40, "reen_start");
        check("reen_no_init", 32'(initialized), 1);
        rst = 1'b0;
        #1;
        check("mid_rst_start", 32'(gyro_start), 0);
        check("mid_rst_init", 32'(initialized), 0);
        check("mid_rst_valid", 32'(sample_valid), 0);
        check("mid_rst_x", 32'(sample_x), 0);
        check("mid_rst_ovr", 32'(overrun_count), 0);
        check("mid_rst_drop", 32'(drop_count), 0);
        check("mid_rst_tmo", 32'(timeout_err), 0);
        enable = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        s   = start_cnt;
        repeat (5) step();
        check("post_rst_idle", start_cnt - s, 0);
        enable = 1'b1;
        step();
        check("reinit_start", 32'(gyro_start), 1);
        wait_init(100, "reinit_done");
        check("single_cycle_starts", start_double, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gyro_sequencer.md
# gyro_sequencer

Controller that sequences the gyro SPI wrapper: issues the one-time initialization, then triggers a read every `SAMPLE_PERIOD` clocks. It captures each calibrated X/Y/Z triple into an output register with a valid/ready handshake. It sits between the gyro wrapper and the sensor-fusion datapath, and it supervises each transaction with a timeout, retry, and overrun/drop accounting.

## Interface
- `SAMPLE_PERIOD`, default 100000: clocks between read ticks (1 kHz at 100 MHz); legal range 2..2^32-1.
- `TIMEOUT`, default 1000000: maximum clocks to wait for `gyro_done_init` or `gyro_done_read`.

- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run request; level.
- `gyro_start`  out  1  one-cycle start pulse to the wrapper.
- `gyro_done_init`  in  1  wrapper init complete; rising edge is the event.
- `gyro_done_read`  in  1  wrapper read complete; rising edge is the event.
- `gyro_x`, `gyro_y`, `gyro_z`  in  16 each  signed calibrated axes, valid when `gyro_done_read` rises.
- `sample_x`, `sample_y`, `sample_z`  out  16 each  registered sample.
- `sample_valid`  out  1  sample register holds unconsumed data.
- `sample_ready`  in  1  consumer accepts when `sample_valid & sample_ready`.
- `initialized`  out  1  init completed since reset.
- `timeout_err`  out  1  sticky; set on any timeout; cleared only by reset.
- `overrun_count`  out  8  ticks dropped because a read was in flight; saturates at 255.
- `drop_count`  out  8  unconsumed samples overwritten; saturates at 255.

## Operation
- Edge detection: `gyro_done_*` are registered once. An event is `done & ~done_q`, so the block works with either level or pulse outputs from the wrapper.
- States:
  - IDLE: waits for `enable`=1, then goes to INIT if `initialized`=0, else WAIT.
  - INIT: `gyro_start`=1 on the entry cycle only. On the done_init event, set `initialized` and go to WAIT.
  - WAIT: when the period tick fires, go to READ. When `enable`=0, go to IDLE.
  - READ: `gyro_start`=1 on the entry cycle only. On the done_read event, capture `gyro_x/y/z` into `sample_*`, set `sample_valid`, and go to WAIT, or to IDLE if `enable`=0.
- Period counter:
  - Runs only while `initialized`=1 and state ≠ IDLE. It counts 0..SAMPLE_PERIOD-1 and wraps.
  - A tick occurs on wrap.
  - Reset to 0 on the INIT→WAIT transition, so the first read starts SAMPLE_PERIOD clocks after init completes.
  - A tick in READ increments `overrun_count` (saturating) and is discarded. There is no queued read.
- Timeout counter:
  - Cleared on entry to INIT or READ; counts every cycle in those states.
  - Reaching TIMEOUT sets `timeout_err` and re-enters the same state, which issues a new start pulse. There is no retry limit.
- Output handshake:
  - `sample_valid` clears on the cycle after `sample_valid & sample_ready`.
  - Capture with `sample_valid`=1 and no accept in the same cycle overwrites the data and increments `drop_count`.
  - Capture and accept in the same cycle: new data loads, `sample_valid` stays 1, and there is no drop.
- `enable` falling in INIT or READ does not abort. The transaction completes or times out first, then the block goes to IDLE. The sample register and counters are retained in IDLE.
- Arithmetic: samples pass through unmodified, with no sign extension or offset. Counters are unsigned and saturating.

## Timing
- Reset values: `gyro_start`=0, `sample_*`=0, `sample_valid`=0, `initialized`=0, `timeout_err`=0, both counts 0, state IDLE, `done_q`=0.
- `enable` high in cycle N (IDLE, uninitialized) → `gyro_start` high in cycle N+1, exactly one cycle.
- done_read rises in cycle M → `sample_*`/`sample_valid` updated at M+1. The state is WAIT at M+1.
- Tick in cycle T (WAIT) → `gyro_start` high at T+1.
- Timeout: with no done event, `gyro_start` re-pulses TIMEOUT+1 cycles after the previous pulse.
- A done event and a timeout in the same cycle: the done event wins, and `timeout_err` is not set.
- Asserting `rst` mid-transaction returns everything to reset values immediately. The wrapper is re-initialized on the next enable.

## Test plan
- Reset/idle: `rst`=0 then 1 with `enable`=0 → all outputs 0 and no `gyro_start` over 1000 cycles.
- Bring-up: SAMPLE_PERIOD=10, `enable`=1, done_init 5 cycles after start, reads with 3-cycle latency and X/Y/Z=0x1234/-7/0x7FFF → one init start, read starts every 10 cycles, samples match exactly, `sample_ready`=1 gives no drops.
- Backpressure: `sample_ready`=0 for 3 reads → `drop_count`=2, last sample retained. Assert ready → `sample_valid` falls the next cycle.
- Overrun: SAMPLE_PERIOD=10, read latency 25 → `overrun_count` increments by 2 per read and saturates at 255.
- Timeout: TIMEOUT=50, suppress done_read once → start re-pulses 51 cycles later, `timeout_err`=1, the next read completes normally.
- Mid-read disable and reset: drop `enable` during READ → sample captured, then IDLE. Pulse `rst` during READ → outputs at reset values, and the next enable issues the init start.
